clock_set_ctrl: RTL and testbench

//  Time-set sequencer for the century clock. Freezes the sec/min/hour/day/month/year

---
 rtl/clock_pkg.sv | 43 ++++
 rtl/days_in_month.sv | 18 +
 rtl/clock_set_ctrl.sv | 146 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the century-clock time-set sequencer.
// State encodings for SET_Y..SET_MIN line up with their field_sel codes.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_Y   = 3'd1,
    ST_SET_MON = 3'd2,
    ST_SET_D   = 3'd3,
    ST_SET_H   = 3'd4,
    ST_SET_MIN = 3'd5,
    ST_COMMIT  = 3'd6
  } state_t;

  localparam logic [2:0] FS_RUN = 3'd0;
  localparam logic [2:0] FS_Y   = 3'd1;
  localparam logic [2:0] FS_MON = 3'd2;
  localparam logic [2:0] FS_D   = 3'd3;
  localparam logic [2:0] FS_H   = 3'd4;
  localparam logic [2:0] FS_MIN = 3'd5;

  localparam logic [6:0] MAX_Y   = 7'd99;
  localparam logic [3:0] MAX_MON = 4'd12;
  localparam logic [4:0] MAX_H   = 5'd23;
  localparam logic [5:0] MAX_MIN = 6'd59;

  function automatic logic is_set(input state_t s);
    return (s == ST_SET_Y) || (s == ST_SET_MON) || (s == ST_SET_D) ||
           (s == ST_SET_H) || (s == ST_SET_MIN);
  endfunction

  function automatic logic [2:0] field_code(input state_t s);
    case (s)
      ST_SET_Y:   return FS_Y;
      ST_SET_MON: return FS_MON;
      ST_SET_D:   return FS_D;
      ST_SET_H:   return FS_H;
      ST_SET_MIN: return FS_MIN;
      default:    return FS_RUN;
    endcase
  endfunction

endpackage

// File: rtl/days_in_month.sv
// Month length lookup; leap year whenever the two low year bits are zero.
// Purely combinational, so it can also serve the day counter's month-end check.
module days_in_month (
  input  logic [3:0] mon,
  input  logic [6:0] y,
  output logic [4:0] dim
);

  always_comb begin
    dim = 5'd31;
    case (mon)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer: freezes the counter chain, edits Y/MON/D/H/MIN, then loads them.
// All outputs registered; button pulses take effect on the following cycle.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [6:0] cur_y,
  input  logic [3:0] cur_mon,
  input  logic [4:0] cur_d,
  input  logic [4:0] cur_h,
  input  logic [5:0] cur_min,
  output logic       run_en,
  output logic       load,
  output logic [6:0] ld_y,
  output logic [3:0] ld_mon,
  output logic [4:0] ld_d,
  output logic [4:0] ld_h,
  output logic [5:0] ld_min,
  output logic [2:0] field_sel,
  output logic       blink
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t          state_q, state_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            blink_d;
  logic [6:0]      y_d;
  logic [3:0]      mon_d;
  logic [4:0]      d_d, h_d;
  logic [5:0]      min_d;
  logic [4:0]      dim;
  logic            any_btn, step_up, step_dn;

  // ld_* are the edit registers themselves
  days_in_month u_dim (.mon(ld_mon), .y(ld_y), .dim(dim));

  assign any_btn = btn_mode | btn_inc | btn_dec;
  assign step_up = !btn_mode &&  btn_inc && !btn_dec;
  assign step_dn = !btn_mode && !btn_inc &&  btn_dec;

  always_comb begin
    state_d = state_q;
    y_d     = ld_y;
    mon_d   = ld_mon;
    d_d     = ld_d;
    h_d     = ld_h;
    min_d   = ld_min;

    case (state_q)
      ST_RUN: if (btn_mode) begin
        state_d = ST_SET_Y;
        y_d     = cur_y;
        mon_d   = cur_mon;
        d_d     = cur_d;
        h_d     = cur_h;
        min_d   = cur_min;
      end
      ST_SET_Y: begin
        if (btn_mode) state_d = ST_SET_MON;
        else if (step_up) y_d = (ld_y >= MAX_Y) ? 7'd0 : ld_y + 7'd1;
        else if (step_dn) y_d = (ld_y == 7'd0) ? MAX_Y : ld_y - 7'd1;
      end
      ST_SET_MON: begin
        if (btn_mode) begin
          state_d = ST_SET_D;
          d_d     = (ld_d > dim) ? dim : ld_d;
        end
        else if (step_up) mon_d = (ld_mon >= MAX_MON) ? 4'd1 : ld_mon + 4'd1;
        else if (step_dn) mon_d = (ld_mon <= 4'd1) ? MAX_MON : ld_mon - 4'd1;
      end
      ST_SET_D: begin
        if (btn_mode) state_d = ST_SET_H;
        else if (step_up) d_d = (ld_d >= dim) ? 5'd1 : ld_d + 5'd1;
        else if (step_dn) d_d = (ld_d <= 5'd1) ? dim : ld_d - 5'd1;
      end
      ST_SET_H: begin
        if (btn_mode) state_d = ST_SET_MIN;
        else if (step_up) h_d = (ld_h >= MAX_H) ? 5'd0 : ld_h + 5'd1;
        else if (step_dn) h_d = (ld_h == 5'd0) ? MAX_H : ld_h - 5'd1;
      end
      ST_SET_MIN: begin
        if (btn_mode) state_d = ST_COMMIT;
        else if (step_up) min_d = (ld_min >= MAX_MIN) ? 6'd0 : ld_min + 6'd1;
        else if (step_dn) min_d = (ld_min == 6'd0) ? MAX_MIN : ld_min - 6'd1;
      end
      default: state_d = ST_RUN;
    endcase

    // Idle abort: edits are dropped, counters keep running on their own values
    if (is_set(state_q) && !any_btn && (tmo_q == TIMEOUT - 16'd1))
      state_d = ST_RUN;

    tmo_d = (!is_set(state_q) || any_btn || (state_d != state_q)) ? 16'd0 : tmo_q + 16'd1;

    blink_d = blink;
    bcnt_d  = bcnt_q + 1'b1;
    if (!is_set(state_q) || (state_d != state_q)) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (bcnt_q == BLINK_LAST) begin
      bcnt_d  = '0;
      blink_d = ~blink;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      tmo_q     <= '0;
      bcnt_q    <= '0;
      blink     <= 1'b0;
      run_en    <= 1'b1;
      load      <= 1'b0;
      field_sel <= FS_RUN;
      ld_y      <= 7'd0;
      ld_mon    <= 4'd1;
      ld_d      <= 5'd1;
      ld_h      <= 5'd0;
      ld_min    <= 6'd0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      bcnt_q    <= bcnt_d;
      blink     <= blink_d;
      run_en    <= (state_d == ST_RUN);
      load      <= (state_d == ST_COMMIT);
      field_sel <= field_code(state_d);
      ld_y      <= y_d;
      ld_mon    <= mon_d;
      ld_d      <= d_d;
      ld_h      <= h_d;
      ld_min    <= min_d;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short blink/timeout periods.
module tb_clock_set_ctrl;

  localparam logic [15:0] TMO = 16'd40;

  logic       clk = 1'b0;
  logic       rst, btn_mode, btn_inc, btn_dec;
  logic [6:0] cur_y;
  logic [3:0] cur_mon;
  logic [4:0] cur_d, cur_h;
  logic [5:0] cur_min;
  logic       run_en, load, blink;
  logic [6:0] ld_y;
  logic [3:0] ld_mon;
  logic [4:0] ld_d, ld_h;
  logic [5:0] ld_min;
  logic [2:0] field_sel;

  int total = 0;
  int passed = 0;
  int load_cnt = 0;

  clock_set_ctrl #(.BLINK_DIV(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_y(cur_y), .cur_mon(cur_mon), .cur_d(cur_d), .cur_h(cur_h), .cur_min(cur_min),
    .run_en(run_en), .load(load), .ld_y(ld_y), .ld_mon(ld_mon), .ld_d(ld_d),
    .ld_h(ld_h), .ld_min(ld_min), .field_sel(field_sel), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    @(negedge clk);
    btn_mode = m; btn_inc = i; btn_dec = d;
    @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
  endtask

  task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi);
    cur_y = 7'(y); cur_mon = 4'(mo); cur_d = 5'(d); cur_h = 5'(h); cur_min = 6'(mi);
  endtask

  initial begin
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    set_cur(23, 5, 17, 8, 30);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_run_en", 32'(run_en), 1);
    check("rst_load", 32'(load), 0);
    check("rst_field", 32'(field_sel), 0);
    check("rst_blink", 32'(blink), 0);
    check("rst_ld_y", 32'(ld_y), 0);
    check("rst_ld_mon", 32'(ld_mon), 1);
    check("rst_ld_d", 32'(ld_d), 1);
    check("rst_ld_h", 32'(ld_h), 0);
    check("rst_ld_min", 32'(ld_min), 0);

    press(0, 1, 0);
    check("run_inc_ignored_y", 32'(ld_y), 0);
    check("run_inc_ignored_fs", 32'(field_sel), 0);

    // Enter set mode: snapshot of live values
    press(1, 0, 0);
    check("enter_field", 32'(field_sel), 1);
    check("enter_run_en", 32'(run_en), 0);
    check("enter_ld_y", 32'(ld_y), 23);
    check("enter_ld_mon", 32'(ld_mon), 5);
    check("enter_ld_d", 32'(ld_d), 17);
    check("enter_ld_h", 32'(ld_h), 8);
    check("enter_ld_min", 32'(ld_min), 30);

    repeat (3) @(negedge clk);
    check("blink_low", 32'(blink), 0);
    @(negedge clk);
    check("blink_high", 32'(blink), 1);

    repeat (24) press(0, 0, 1);
    check("y_dec_wrap", 32'(ld_y), 99);
    press(0, 1, 0);
    check("y_inc_wrap", 32'(ld_y), 0);
    press(0, 1, 1);
    check("y_inc_dec_noop", 32'(ld_y), 0);
    press(1, 1, 0);
    check("mode_inc_field", 32'(field_sel), 2);
    check("mode_inc_y_held", 32'(ld_y), 0);
    check("blink_cleared", 32'(blink), 0);

    repeat (7) press(0, 1, 0);
    check("mon_inc_12", 32'(ld_mon), 12);
    press(0, 1, 0);
    check("mon_inc_wrap", 32'(ld_mon), 1);
    press(0, 0, 1);
    check("mon_dec_wrap", 32'(ld_mon), 12);

    press(1, 0, 0);
    check("d_field", 32'(field_sel), 3);
    check("d_no_clamp", 32'(ld_d), 17);
    repeat (14) press(0, 1, 0);
    check("d_inc_31", 32'(ld_d), 31);
    press(0, 1, 0);
    check("d_inc_wrap", 32'(ld_d), 1);
    press(0, 0, 1);
    check("d_dec_wrap", 32'(ld_d), 31);

    press(1, 0, 0);
    check("h_field", 32'(field_sel), 4);
    repeat (9) press(0, 0, 1);
    check("h_dec_wrap", 32'(ld_h), 23);
    press(0, 1, 0);
    check("h_inc_wrap", 32'(ld_h), 0);

    press(1, 0, 0);
    check("min_field", 32'(field_sel), 5);
    repeat (29) press(0, 1, 0);
    check("min_inc_59", 32'(ld_min), 59);
    press(0, 1, 0);
    check("min_inc_wrap", 32'(ld_min), 0);
    press(0, 0, 1);
    check("min_dec_wrap", 32'(ld_min), 59);

    press(1, 0, 0);
    check("commit_load", 32'(load), 1);
    check("commit_run_en", 32'(run_en), 0);
    check("commit_ld_y", 32'(ld_y), 0);
    check("commit_ld_mon", 32'(ld_mon), 12);
    check("commit_ld_d", 32'(ld_d), 31);
    check("commit_ld_h", 32'(ld_h), 0);
    check("commit_ld_min", 32'(ld_min), 59);
    @(negedge clk);
    check("post_commit_load", 32'(load), 0);
    check("post_commit_run_en", 32'(run_en), 1);
    check("post_commit_field", 32'(field_sel), 0);
    check("one_load_pulse", 32'(load_cnt), 1);
    check("run_blink", 32'(blink), 0);

    // Day clamp into February, non-leap year
    set_cur(23, 3, 31, 10, 15);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    check("clamp_mon_feb", 32'(ld_mon), 2);
    press(1, 0, 0);
    check("clamp_d_28", 32'(ld_d), 28);
    press(0, 1, 0);
    check("feb28_inc_wrap", 32'(ld_d), 1);
    repeat (3) press(1, 0, 0);
    check("commit2_load", 32'(load), 1);
    check("commit2_ld_d", 32'(ld_d), 1);

    // Leap year, then let SET_H idle out
    set_cur(24, 3, 31, 10, 15);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    check("clamp_d_29", 32'(ld_d), 29);
    press(1, 0, 0);
    check("tmo_enter_h", 32'(field_sel), 4);
    repeat (int'(TMO) - 1) @(negedge clk);
    check("tmo_not_yet", 32'(field_sel), 4);
    check("tmo_not_yet_run_en", 32'(run_en), 0);
    @(negedge clk);
    check("tmo_field", 32'(field_sel), 0);
    check("tmo_run_en", 32'(run_en), 1);
    @(negedge clk);
    check("tmo_no_load", 32'(load_cnt), 2);

    // Reset in the middle of an edit
    repeat (3) press(1, 0, 0);
    check("rst_mid_field", 32'(field_sel), 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_fs", 32'(field_sel), 0);
    check("rst_mid_run_en", 32'(run_en), 1);
    check("rst_mid_ld_y", 32'(ld_y), 0);
    @(negedge clk);
    check("rst_mid_no_load", 32'(load_cnt), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
